muldiv_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit for the 55-instruction MIPS core.
- Sits beside the register file. Consumes the rs/rt read data (`rdata1`/`rdata2`) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI and LO registers. MFHI/MFLO route `hi`/`lo` back to the register-file write port.
- Raises `busy` while an operation is in flight so the control unit can stall the pipeline.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU in 32 radix-2 steps, MTHI/MTLO direct.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state_q, state_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_p_q, neg_p_d;
    logic              neg_r_q, neg_r_d;
    logic              done_q, done_d;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    mul_sum;
    logic [W2-1:0]     mul_next;
    logic [WIDTH:0]    div_trial;
    logic [WIDTH-1:0]  div_diff;
    logic              div_ge;
    logic [W2-1:0]     div_next;
    logic [W2-1:0]     prod_signed;
    logic [WIDTH-1:0]  quo_signed, rem_signed;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // acc holds {partial product, remaining multiplier bits} while multiplying
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};

    // acc holds {partial remainder, dividend bits / quotient bits} while dividing
    assign div_trial = acc_q[W2-1:WIDTH-1];
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_diff  = div_trial[WIDTH-1:0] - opnd_q;
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_signed = neg_p_q ? -acc_q : acc_q;
    assign quo_signed  = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_signed  = neg_r_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d = op[1];
                            cnt_d    = '0;
                            neg_r_d  = a_neg;
                            // divide-by-zero keeps the all-ones quotient unnegated
                            neg_p_d  = (a_neg ^ b_neg) & ~(op[1] && b == '0);
                            if (op[1]) begin
                                acc_d  = {{WIDTH{1'b0}}, mag_a};
                                opnd_d = mag_b;
                            end else begin
                                acc_d  = {{WIDTH{1'b0}}, mag_b};
                                opnd_d = mag_a;
                            end
                            state_d = RUN;
`ifdef MULDIV_FAST_MUL_EN
                            if (!op[1]) begin
                                acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                                state_d = FINISH;
                            end
`endif
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (is_div_q) begin
                    hi_d = rem_signed;
                    lo_d = quo_signed;
                end else begin
                    hi_d = prod_signed[W2-1:WIDTH];
                    lo_d = prod_signed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random model vectors, and sequence corner cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    res_t        sb_q[$];
    vec_t        vecs[12];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_hi, cur_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with n0 = edges elapsed since the start edge.
    task automatic wait_result(input int n0, input int lat);
        int   n;
        res_t r;
        n = n0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        r = sb_q.pop_front();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done after %0d cycles, expected %0d", n, lat);
        end else begin
            check("latency", n, lat);
            check("hi", hi, r.hi);
            check("lo", lo, r.lo);
            check("busy_at_done", {31'b0, busy}, 32'd0);
            cur_hi = r.hi;
            cur_lo = r.lo;
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo);
        res_t r;
        r.hi = ehi;
        r.lo = elo;
        sb_q.push_back(r);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        wait_result(0, o[1] ? DIV_LAT : MUL_LAT);
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic [2:0]         ro;
        logic signed [63:0] sp;
        logic signed [31:0] sa, sbv, sq, sr;
        logic [63:0]        up;
        int                 done_seen;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{3'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};

        rst = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'hAAAA5555;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start_hi", hi, 32'd0);

        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_done", {31'b0, done}, 32'd0);

        start = 1'b1; op = 3'd5; a = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'h12345678);

        start = 1'b1; op = 3'd6; a = 32'h0BADBEEF;
        @(negedge clk);
        start = 1'b0;
        check("nop_busy", {31'b0, busy}, 32'd0);
        check("nop_lo", lo, 32'hCAFEF00D);
        cur_hi = 32'h12345678;
        cur_lo = 32'hCAFEF00D;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (rb == 32'd0 || rb == 32'hFFFFFFFF) rb = 32'd5;
            sa = ra; sbv = rb;
            case (ro)
                3'd0: begin sp = sa * sbv; do_op(ro, ra, rb, sp[63:32], sp[31:0]); end
                3'd1: begin up = {32'b0, ra} * {32'b0, rb}; do_op(ro, ra, rb, up[63:32], up[31:0]); end
                3'd2: begin sq = sa / sbv; sr = sa % sbv; do_op(ro, ra, rb, sr, sq); end
                default: do_op(ro, ra, rb, ra % rb, ra / rb);
            endcase
        end

        begin
            res_t r;
            r.hi = 32'd1; r.lo = 32'd333;
            sb_q.push_back(r);
            start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            check("hold_lo_while_busy", lo, cur_lo);
            check("hold_hi_while_busy", hi, cur_hi);
            start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
            @(negedge clk);
            start = 1'b0; op = 3'd7;
            check("mtlo_ignored_busy", {31'b0, busy}, 32'd1);
            check("mtlo_ignored_lo", lo, cur_lo);
            wait_result(5, DIV_LAT);
        end

        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);

        do_op(3'd3, 32'd9, 32'd2, 32'd1, 32'd4);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
